// File: rtl/sincos_share_arb.sv
// sincos_share_arb
// Round-robin scheduler sharing one fixed-latency, non-stallable sin/cos
// engine between NUM_REQ requesters. At most one theta is issued per cycle;
// a latency-matched tag line steers each engine result back to its issuer,
// and per-requester credit counters bound the number of operations in flight.
//
// Optional build macro: SINCOS_ARB_CHECK_EN
//   defined   : err is a sticky flag raised on engine/tag protocol violations
//   undefined : err is tied low and no check logic is built
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/theta   per-requester theta offer (theta i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready         one-hot combinational grant
//   eng_theta_valid   registered issue strobe to the engine
//   eng_theta         registered theta to the engine
//   eng_sin/cos(_valid) engine results, PIPE_LATENCY cycles after issue
//   rsp_valid         one-hot owner of the registered result
//   rsp_sin/cos       registered results
//   busy              credits outstanding or an issue in progress
//   err               sticky protocol error (check build only)

module sincos_share_arb #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int PIPE_LATENCY    = 149,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_theta,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          eng_theta_valid,
    output logic [DATA_WIDTH-1:0]         eng_theta,
    input  logic                          eng_sin_valid,
    input  logic                          eng_cos_valid,
    input  logic [DATA_WIDTH-1:0]         eng_sin,
    input  logic [DATA_WIDTH-1:0]         eng_cos,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_sin,
    output logic [DATA_WIDTH-1:0]         rsp_cos,
    output logic                          busy,
    output logic                          err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]        rr_ptr_q;
    logic [CNT_W-1:0]        outst_q [NUM_REQ];
    logic [CNT_W-1:0]        outst_d [NUM_REQ];
    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      grant;
    logic                    grant_any;
    logic [IDX_W-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0]   grant_theta;

    logic                    eng_v_q;
    logic [DATA_WIDTH-1:0]   eng_theta_q;
    logic [IDX_W-1:0]        eng_idx_q;

    logic [PIPE_LATENCY-1:0] tag_v_q;
    logic [IDX_W-1:0]        tag_idx_q [PIPE_LATENCY];
    logic                    tag_out_v;
    logic [IDX_W-1:0]        tag_out_idx;

    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [NUM_REQ-1:0]      rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_sin_q;
    logic [DATA_WIDTH-1:0]   rsp_cos_q;
    logic                    busy_d;

    // Eligibility is gated by rst_n so no handshake can complete in a reset cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = rst_n & req_valid[i] & (outst_q[i] < MAX_CNT);
        end
    end

    // Rotating priority: search starts one past the last grantee.
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_any && elig[IDX_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_theta = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_theta = req_theta[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            eng_v_q     <= 1'b0;
            eng_theta_q <= '0;
            eng_idx_q   <= '0;
        end else begin
            eng_v_q <= grant_any;
            if (grant_any) begin
                rr_ptr_q    <= grant_idx;
                eng_theta_q <= grant_theta;
                eng_idx_q   <= grant_idx;
            end
        end
    end

    // Tag line: its last stage lines up with the engine result cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            tag_v_q      <= {tag_v_q[PIPE_LATENCY-2:0], eng_v_q};
            tag_idx_q[0] <= eng_idx_q;
            for (int s = 1; s < PIPE_LATENCY; s++) begin
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign tag_out_v   = tag_v_q[PIPE_LATENCY-1];
    assign tag_out_idx = tag_idx_q[PIPE_LATENCY-1];

    // Results are captured only when a tag is present; untagged results are dropped.
    assign rsp_valid_d = tag_out_v ? (NUM_REQ'(1) << tag_out_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_sin_q   <= '0;
            rsp_cos_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (tag_out_v) begin
                rsp_sin_q <= eng_sin;
                rsp_cos_q <= eng_cos;
            end
        end
    end

    // A grant and a return for the same requester cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i];
            if (grant[i] && !rsp_valid_q[i]) begin
                outst_d[i] = outst_q[i] + CNT_W'(1);
            end else if (!grant[i] && rsp_valid_q[i]) begin
                outst_d[i] = outst_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    always_comb begin
        busy_d = eng_v_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (outst_q[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

`ifdef SINCOS_ARB_CHECK_EN
    logic err_q;
    logic proto_bad;

    assign proto_bad = (tag_out_v != (eng_sin_valid & eng_cos_valid))
                     | (eng_sin_valid != eng_cos_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (proto_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Engine strobes are only consulted by the protocol check.
    logic unused_eng_valid;
    assign unused_eng_valid = eng_sin_valid ^ eng_cos_valid;
    assign err = 1'b0;
`endif

    assign req_ready       = grant;
    assign eng_theta_valid = eng_v_q;
    assign eng_theta       = eng_theta_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_sin         = rsp_sin_q;
    assign rsp_cos         = rsp_cos_q;
    assign busy            = busy_d;

endmodule

// File: tb/tb_sincos_share_arb.sv
// Testbench for sincos_share_arb: behavioural delay-line engine plus a
// transaction-level reference model (grant search, credit counts and a
// queue of expected responses keyed by their due cycle).
module tb_sincos_share_arb;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int PL   = 149;
    localparam int MAXO = 8;
    localparam int RLAT = PL + 2;
`ifdef SINCOS_ARB_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_theta = '0;
    logic [NREQ-1:0]    req_ready;
    logic               eng_theta_valid;
    logic [DW-1:0]      eng_theta;
    logic               eng_sin_valid, eng_cos_valid;
    logic [DW-1:0]      eng_sin, eng_cos;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_sin, rsp_cos;
    logic               busy, err;
    logic               inj_sin = 1'b0;

    sincos_share_arb #(
        .NUM_REQ(NREQ), .DATA_WIDTH(DW), .PIPE_LATENCY(PL), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
        .eng_theta_valid(eng_theta_valid), .eng_theta(eng_theta),
        .eng_sin_valid(eng_sin_valid), .eng_cos_valid(eng_cos_valid),
        .eng_sin(eng_sin), .eng_cos(eng_cos),
        .rsp_valid(rsp_valid), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
        .busy(busy), .err(err)
    );

    function automatic logic [DW-1:0] f_sin(input logic [DW-1:0] x);
        return x ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic logic [DW-1:0] f_cos(input logic [DW-1:0] x);
        return {x[31:0], x[63:32]} + 64'd1;
    endfunction

    function automatic logic [NREQ*DW-1:0] rand_th();
        logic [NREQ*DW-1:0] r;
        for (int k = 0; k < NREQ * 2; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural engine: fixed PL-cycle delay line, shares rst_n.
    logic [PL-1:0] pv;
    logic [DW-1:0] pth [PL];
    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < PL; k++) pth[k] <= '0;
        end else begin
            pv     <= {pv[PL-2:0], eng_theta_valid};
            pth[0] <= eng_theta;
            for (int k = 1; k < PL; k++) pth[k] <= pth[k-1];
        end
    end
    assign eng_sin_valid = pv[PL-1] | inj_sin;
    assign eng_cos_valid = pv[PL-1];
    assign eng_sin       = f_sin(pth[PL-1]);
    assign eng_cos       = f_cos(pth[PL-1]);

    // Reference model
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] s;
        logic [DW-1:0] c;
    } rsp_t;

    rsp_t          exp_q[$];
    int            outst_m [NREQ];
    int            rr_m;
    int            cyc;
    int            g_m;
    logic          exp_etv;
    logic [DW-1:0] exp_eth;
    logic [DW-1:0] exp_rs, exp_rc;
    logic [NREQ-1:0] exp_ready, exp_rspv;
    logic          exp_busy;

    int pass_n  = 0;
    int total_n = 0;

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) outst_m[i] = 0;
        rr_m    = NREQ - 1;
        exp_etv = 1'b0;
        exp_eth = '0;
        exp_rs  = '0;
        exp_rc  = '0;
        cyc     = 0;
    endtask

    // Drive one cycle's inputs and compute what the DUT must show this cycle.
    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] th);
        @(negedge clk);
        req_valid = v;
        req_theta = th;
        inj_sin   = 1'b0;
        #1;
        g_m = -1;
        for (int k = 1; k <= NREQ; k++) begin
            automatic int c = (rr_m + k) % NREQ;
            if (g_m < 0 && v[c] && outst_m[c] < MAXO) g_m = c;
        end
        exp_ready = '0;
        if (g_m >= 0) exp_ready[g_m] = 1'b1;
        exp_rspv = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_rspv[exp_q[0].idx] = 1'b1;
            exp_rs = exp_q[0].s;
            exp_rc = exp_q[0].c;
        end
        exp_busy = exp_etv;
        for (int i = 0; i < NREQ; i++) if (outst_m[i] != 0) exp_busy = 1'b1;
    endtask

    task automatic advance();
        logic [DW-1:0] t;
        if (exp_rspv != '0) begin
            outst_m[exp_q[0].idx]--;
            void'(exp_q.pop_front());
        end
        if (g_m >= 0) begin
            t = req_theta[g_m*DW +: DW];
            outst_m[g_m]++;
            rr_m = g_m;
            exp_q.push_back('{cyc + RLAT, g_m, f_sin(t), f_cos(t)});
            exp_eth = t;
        end
        exp_etv = (g_m >= 0);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        inj_sin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        req_theta = rand_th();
        #1;
        total_n++;
        if (req_ready !== '0) $display("FAIL reset_ready_in_reset: got %b want 0000", req_ready);
        else pass_n++;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        model_reset();
        #1;
        total_n++;
        if ({eng_theta_valid, rsp_valid, busy, err, req_ready} !== '0)
            $display("FAIL reset_ctrl: got etv=%b rspv=%b busy=%b err=%b rdy=%b want all 0",
                     eng_theta_valid, rsp_valid, busy, err, req_ready);
        else pass_n++;
        total_n++;
        if ({eng_theta, rsp_sin, rsp_cos} !== '0)
            $display("FAIL reset_data: got eth=%h rs=%h rc=%h want 0", eng_theta, rsp_sin, rsp_cos);
        else pass_n++;
    endtask

    task automatic test_single();
        logic [NREQ*DW-1:0] th;
        do_reset();
        for (int c = 0; c < RLAT + 6; c++) begin
            th = '0;
            th[2*DW +: DW] = 64'h3FF0000000000000;
            drive((c == 0) ? 4'b0100 : 4'b0000, th);
            total_n++;
            if (req_ready !== exp_ready) $display("FAIL single_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            else pass_n++;
            total_n++;
            if (eng_theta_valid !== exp_etv || eng_theta !== exp_eth)
                $display("FAIL single_issue c=%0d: got %b/%h want %b/%h", c, eng_theta_valid, eng_theta, exp_etv, exp_eth);
            else pass_n++;
            total_n++;
            if (rsp_valid !== exp_rspv) $display("FAIL single_rspv c=%0d: got %b want %b", c, rsp_valid, exp_rspv);
            else pass_n++;
            total_n++;
            if (rsp_sin !== exp_rs || rsp_cos !== exp_rc)
                $display("FAIL single_data c=%0d: got %h/%h want %h/%h", c, rsp_sin, rsp_cos, exp_rs, exp_rc);
            else pass_n++;
            total_n++;
            if (busy !== exp_busy || err !== 1'b0)
                $display("FAIL single_busy_err c=%0d: got %b/%b want %b/0", c, busy, err, exp_busy);
            else pass_n++;
            advance();
        end
    endtask

    task automatic test_fairness();
        int order [$];
        do_reset();
        for (int c = 0; c < RLAT + 12; c++) begin
            drive((c < 8) ? 4'b1111 : 4'b0000, rand_th());
            if (c < 8) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) order.push_back(i);
            end
            total_n++;
            if (req_ready !== exp_ready) $display("FAIL fair_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            else pass_n++;
            total_n++;
            if (rsp_valid !== exp_rspv || rsp_sin !== exp_rs)
                $display("FAIL fair_rsp c=%0d: got %b/%h want %b/%h", c, rsp_valid, rsp_sin, exp_rspv, exp_rs);
            else pass_n++;
            advance();
        end
        total_n++;
        if (order.size() != 8) $display("FAIL fair_count: got %0d want 8", order.size());
        else pass_n++;
        for (int k = 0; k < order.size(); k++) begin
            total_n++;
            if (order[k] != k % NREQ) $display("FAIL fair_order k=%0d: got %0d want %0d", k, order[k], k % NREQ);
            else pass_n++;
        end
    endtask

    task automatic test_credit_limit();
        int gcnt = 0;
        int first_rsp = -1;
        int regrant = -1;
        do_reset();
        for (int c = 0; c < RLAT + 8; c++) begin
            drive(4'b0010, rand_th());
            if (c < 20 && req_ready[1]) gcnt++;
            if (first_rsp < 0 && rsp_valid[1]) first_rsp = c;
            if (c >= 20 && regrant < 0 && req_ready[1]) regrant = c;
            total_n++;
            if (req_ready !== exp_ready) $display("FAIL credit_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            else pass_n++;
            total_n++;
            if (rsp_valid !== exp_rspv || busy !== exp_busy)
                $display("FAIL credit_rsp c=%0d: got %b/%b want %b/%b", c, rsp_valid, busy, exp_rspv, exp_busy);
            else pass_n++;
            advance();
        end
        total_n++;
        if (gcnt != MAXO) $display("FAIL credit_grants: got %0d want %0d", gcnt, MAXO);
        else pass_n++;
        total_n++;
        if (first_rsp != RLAT || regrant != first_rsp + 1)
            $display("FAIL credit_regrant: got rsp=%0d grant=%0d want rsp=%0d grant=%0d",
                     first_rsp, regrant, RLAT, RLAT + 1);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        int grants = 0;
        do_reset();
        for (int c = 0; c < 2 * RLAT + 40; c++) begin
            drive(4'b0001, rand_th());
            if (req_ready[0]) grants++;
            total_n++;
            if (req_ready !== exp_ready) $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            else pass_n++;
            total_n++;
            if (eng_theta !== exp_eth || rsp_valid !== exp_rspv || rsp_cos !== exp_rc)
                $display("FAIL b2b_path c=%0d: got %h/%b/%h want %h/%b/%h",
                         c, eng_theta, rsp_valid, rsp_cos, exp_eth, exp_rspv, exp_rc);
            else pass_n++;
            total_n++;
            if (outst_m[0] < 0 || outst_m[0] > MAXO) $display("FAIL b2b_credit c=%0d: got %0d want 0..%0d", c, outst_m[0], MAXO);
            else pass_n++;
            advance();
        end
        // 8 grants per 152-cycle round trip: 0..7, 152..159, 304..311.
        total_n++;
        if (grants != 3 * MAXO) $display("FAIL b2b_grants: got %0d want %0d", grants, 3 * MAXO);
        else pass_n++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v = NREQ'($urandom) | NREQ'($urandom);
            drive(v, rand_th());
            total_n++;
            if (req_ready !== exp_ready) $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            else pass_n++;
            total_n++;
            if (eng_theta_valid !== exp_etv || eng_theta !== exp_eth)
                $display("FAIL rand_issue c=%0d: got %b/%h want %b/%h", c, eng_theta_valid, eng_theta, exp_etv, exp_eth);
            else pass_n++;
            total_n++;
            if (rsp_valid !== exp_rspv || rsp_sin !== exp_rs || rsp_cos !== exp_rc)
                $display("FAIL rand_rsp c=%0d: got %b/%h/%h want %b/%h/%h",
                         c, rsp_valid, rsp_sin, rsp_cos, exp_rspv, exp_rs, exp_rc);
            else pass_n++;
            total_n++;
            if (busy !== exp_busy || err !== 1'b0)
                $display("FAIL rand_busy_err c=%0d: got %b/%b want %b/0", c, busy, err, exp_busy);
            else pass_n++;
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0001, rand_th());
            total_n++;
            if (req_ready !== exp_ready) $display("FAIL mid_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            else pass_n++;
            advance();
        end
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        model_reset();
        #1;
        total_n++;
        if ({eng_theta_valid, eng_theta, rsp_valid, rsp_sin, rsp_cos, busy, err} !== '0)
            $display("FAIL mid_outputs: got etv=%b eth=%h rspv=%b busy=%b err=%b want 0",
                     eng_theta_valid, eng_theta, rsp_valid, busy, err);
        else pass_n++;
        for (int c = 0; c < RLAT + 5; c++) begin
            drive(4'b0000, '0);
            total_n++;
            if (rsp_valid !== exp_rspv || busy !== exp_busy)
                $display("FAIL mid_flush c=%0d: got %b/%b want %b/%b", c, rsp_valid, busy, exp_rspv, exp_busy);
            else pass_n++;
            advance();
        end
        drive(4'b1111, rand_th());
        total_n++;
        if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready);
        else pass_n++;
        advance();
    endtask

    task automatic test_err();
        logic exp_err;
        do_reset();
        drive(4'b0000, '0);
        inj_sin = 1'b1;
        total_n++;
        if (err !== 1'b0) $display("FAIL err_before: got %b want 0", err);
        else pass_n++;
        advance();
        for (int c = 0; c < 6; c++) begin
            drive(4'b0000, '0);
            exp_err = CHK_EN;
            total_n++;
            if (err !== exp_err) $display("FAIL err_sticky c=%0d: got %b want %b", c, err, exp_err);
            else pass_n++;
            total_n++;
            if (rsp_valid !== exp_rspv) $display("FAIL err_drop c=%0d: got %b want %b", c, rsp_valid, exp_rspv);
            else pass_n++;
            advance();
        end
        do_reset();
        #1;
        total_n++;
        if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err);
        else pass_n++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_credit_limit();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_err();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
